// File: rtl/timer_cmp2rib.sv
// timer_cmp2rib: raises a level interrupt when the live 64-bit timer count reaches a programmable compare value; RIB slave registers.
// Optional periodic re-arm (PERIOD register, CTRL.PERIODIC) is compiled in with `define TIMER_CMP_PERIODIC_EN.
module timer_cmp2rib #(
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned ADDR_LSB = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [63:0] i_timer_cnt,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy,
    output logic        o_irq
);

    localparam logic [31:0] OFF_CMP_LO = 32'h0000_0000;
    localparam logic [31:0] OFF_CMP_HI = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS = 32'h0000_000C;
    localparam logic [31:0] OFF_PERIOD = 32'h0000_0010;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] addr_off;
    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_ctrl;
    logic        sel_status;
    logic        sel_period;

    logic [63:0] cmp;
    logic [63:0] cmp_next;
    logic        ctrl_en;
    logic        ctrl_periodic;
    logic [31:0] period;
    logic        pending;
    logic        match;
    logic        status_clr;
    logic [31:0] rd_mux;

    // Valid/ready: a request is granted unless a response is still waiting for the master
    // (rsp=1, rdy=0); the granted access commits at the edge and its response follows one cycle later.
    assign o_ribs_gnt = i_ribs_req & ~(o_ribs_rsp & ~i_ribs_rdy);
    assign acc        = i_ribs_req & o_ribs_gnt;
    assign wr_acc     = acc & i_ribs_wrcs;
    assign rd_acc     = acc & ~i_ribs_wrcs;

    assign addr_off   = i_ribs_addr & ((32'd1 << ADDR_LSB) - 32'd1);
    assign sel_cmp_lo = (addr_off == OFF_CMP_LO);
    assign sel_cmp_hi = (addr_off == OFF_CMP_HI);
    assign sel_ctrl   = (addr_off == OFF_CTRL);
    assign sel_status = (addr_off == OFF_STATUS);
    assign sel_period = (addr_off == OFF_PERIOD);

    assign match      = ctrl_en & (i_timer_cnt >= cmp);
    assign status_clr = wr_acc & sel_status & i_ribs_mask[0] & i_ribs_wdata[0];

`ifdef TIMER_CMP_PERIODIC_EN
    logic reload;
    assign reload = ctrl_periodic & match;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctrl_periodic <= 1'b0;
            period        <= '0;
        end else if (wr_acc) begin
            if (sel_ctrl && i_ribs_mask[0]) begin
                ctrl_periodic <= i_ribs_wdata[1];
            end
            if (sel_period) begin
                period <= apply_mask(period, i_ribs_wdata, i_ribs_mask);
            end
        end
    end
`else
    assign ctrl_periodic = 1'b0;
    assign period        = '0;
`endif

    // A bus write to one compare half overrides a reload for that half only; the
    // other half keeps its pre-reload value.
    always_comb begin
        cmp_next = cmp;
`ifdef TIMER_CMP_PERIODIC_EN
        if (reload) begin
            cmp_next = cmp + {32'b0, period};
        end
`endif
        if (wr_acc && sel_cmp_lo) begin
            cmp_next = {cmp[63:32], apply_mask(cmp[31:0], i_ribs_wdata, i_ribs_mask)};
        end
        if (wr_acc && sel_cmp_hi) begin
            cmp_next = {apply_mask(cmp[63:32], i_ribs_wdata, i_ribs_mask), cmp[31:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cmp     <= CMP_RST;
            ctrl_en <= 1'b0;
        end else begin
            cmp <= cmp_next;
            if (wr_acc && sel_ctrl && i_ribs_mask[0]) begin
                ctrl_en <= i_ribs_wdata[0];
            end
        end
    end

    // Set has priority over a software clear so a persisting match is never lost.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pending <= 1'b0;
            o_irq   <= 1'b0;
        end else begin
            if (match) begin
                pending <= 1'b1;
            end else if (status_clr) begin
                pending <= 1'b0;
            end
            o_irq <= pending;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (sel_cmp_lo) rd_mux = cmp[31:0];
        if (sel_cmp_hi) rd_mux = cmp[63:32];
        if (sel_ctrl)   rd_mux = {30'b0, ctrl_periodic, ctrl_en};
        if (sel_status) rd_mux = {31'b0, pending};
        if (sel_period) rd_mux = period;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_ribs_rsp   <= 1'b0;
            o_ribs_rdata <= '0;
        end else begin
            if (acc) begin
                o_ribs_rsp <= 1'b1;
            end else if (i_ribs_rdy) begin
                o_ribs_rsp <= 1'b0;
            end
            if (rd_acc) begin
                o_ribs_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_timer_cmp2rib.sv
// tb_timer_cmp2rib: directed scenarios plus randomized bus/timer traffic against a register-level reference model.
// Periodic scenarios are selected with `define TIMER_CMP_PERIODIC_EN, matching the design build.
module tb_timer_cmp2rib;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef TIMER_CMP_PERIODIC_EN
    localparam bit HAS_PER = 1'b1;
`else
    localparam bit HAS_PER = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [63:0] cnt;
    logic [31:0] addr;
    logic        wrcs;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic        gnt;
    logic        rsp;
    logic        rdy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_cmp2rib dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_timer_cnt  (cnt),
        .i_ribs_addr  (addr),
        .i_ribs_wrcs  (wrcs),
        .i_ribs_mask  (mask),
        .i_ribs_wdata (wdata),
        .o_ribs_rdata (rdata),
        .i_ribs_req   (req),
        .o_ribs_gnt   (gnt),
        .o_ribs_rsp   (rsp),
        .i_ribs_rdy   (rdy),
        .o_irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents as software sees them, updated once per clock.
    logic [63:0] m_cmp = CMP_RST;
    logic        m_en = 1'b0, m_per = 1'b0, m_pending = 1'b0, m_irq = 1'b0;
    logic [31:0] m_period = '0, m_rdata = '0;
    logic        m_rsp = 1'b0, m_last_rd = 1'b0;
    logic        m_acc, m_hit, m_wr;
    logic [7:0]  m_off;
    logic [63:0] n_cmp;
    logic [31:0] n_ctrl, n_period, rd_val;
    logic        n_en, n_per, n_pending;

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        m_acc    = req && !(m_rsp && !rdy);
        m_wr     = m_acc && wrcs;
        m_off    = addr[7:0];
        m_hit    = m_en && (cnt >= m_cmp);
        n_cmp    = m_cmp;
        n_ctrl   = mmerge({30'b0, m_per, m_en}, wdata, mask);
        n_en     = m_en;
        n_per    = m_per;
        n_period = m_period;
        if (HAS_PER && m_per && m_hit) n_cmp = m_cmp + {32'b0, m_period};
        if (m_wr && m_off == 8'h00) n_cmp = {m_cmp[63:32], mmerge(m_cmp[31:0], wdata, mask)};
        if (m_wr && m_off == 8'h04) n_cmp = {mmerge(m_cmp[63:32], wdata, mask), m_cmp[31:0]};
        if (m_wr && m_off == 8'h08) begin
            n_en  = n_ctrl[0];
            n_per = HAS_PER && n_ctrl[1];
        end
        if (m_wr && m_off == 8'h10 && HAS_PER) n_period = mmerge(m_period, wdata, mask);
        n_pending = m_pending;
        if (m_wr && m_off == 8'h0C && mask[0] && wdata[0]) n_pending = 1'b0;
        if (m_hit) n_pending = 1'b1;
        case (m_off)
            8'h00:   rd_val = m_cmp[31:0];
            8'h04:   rd_val = m_cmp[63:32];
            8'h08:   rd_val = {30'b0, m_per, m_en};
            8'h0C:   rd_val = {31'b0, m_pending};
            8'h10:   rd_val = HAS_PER ? m_period : 32'h0;
            default: rd_val = 32'h0;
        endcase
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cmp <= CMP_RST; m_en <= 1'b0; m_per <= 1'b0; m_period <= '0;
            m_pending <= 1'b0; m_irq <= 1'b0; m_rsp <= 1'b0; m_rdata <= '0; m_last_rd <= 1'b0;
        end else begin
            m_cmp <= n_cmp; m_en <= n_en; m_per <= n_per; m_period <= n_period;
            m_pending <= n_pending; m_irq <= m_pending;
            if (m_acc) begin
                m_rsp     <= 1'b1;
                m_last_rd <= !wrcs;
                if (!wrcs) m_rdata <= rd_val;
            end else if (rdy) begin
                m_rsp <= 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single access with rdy=1; starts and ends just after a rising edge.
    task automatic bus_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d,
                            input logic [3:0] m, output logic [31:0] rd);
        int n = 0;
        req = 1'b1; wrcs = wr; addr = a; wdata = d; mask = m; rdy = 1'b1;
        @(negedge clk);
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gnt !== 1'b1) begin
            errors++;
            $display("FAIL bus_gnt_timeout addr=%h: gnt=%b required 1", a, gnt);
        end
        tick;
        req = 1'b0; wrcs = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp !== 1'b1) begin
            errors++;
            $display("FAIL bus_rsp addr=%h: rsp=%b required 1", a, rsp);
        end
        rd = rdata;
        tick;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rstn = 1'b0; req = 1'b0; wrcs = 1'b0; addr = '0; wdata = '0; mask = '0; rdy = 1'b1;
        cnt = '1;
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        bus_xfer(32'h00, 1'b1, 32'h0000_1234, 4'hF, rd);
        bus_xfer(32'h08, 1'b1, 32'h1, 4'hF, rd);
        tick;
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq: irq=%b required 1", irq); end
        @(posedge clk); #1;
        req = 1'b1; wrcs = 1'b0; addr = 32'h00; rdy = 1'b0;
        tick;
        req = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b required 0", irq); end
        checks++;
        if (rsp !== 1'b0) begin errors++; $display("FAIL reset_rsp: rsp=%b required 0", rsp); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: rdata=%h required 0", rdata); end
        rdy = 1'b1; cnt = '0;
        tick;
        rstn = 1'b1;
        tick;
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo: read %h required ffffffff", rd); end
        bus_xfer(32'h04, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: read %h required ffffffff", rd); end
        bus_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: read %h required 0", rd); end
    endtask

    task automatic test_one_shot;
        logic [31:0] rd;
        cnt = 64'hFE;
        bus_xfer(32'h00, 1'b1, 32'h100, 4'hF, rd);
        bus_xfer(32'h04, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h08, 1'b1, 32'h1, 4'hF, rd);
        for (int i = 0; i < 5; i++) begin
            cnt = 64'hFE + 64'(i);
            @(negedge clk);
            checks++;
            if (irq !== (i == 4)) begin
                errors++;
                $display("FAIL one_shot_irq step %0d: irq=%b required %b", i, irq, (i == 4));
            end
            tick;
        end
        bus_xfer(32'h0C, 1'b1, 32'h1, 4'hF, rd);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL one_shot_clear_while_match: irq=%b required 1", irq); end
        @(posedge clk); #1;
        bus_xfer(32'h04, 1'b1, 32'h1, 4'hF, rd);
        bus_xfer(32'h0C, 1'b1, 32'h1, 4'hF, rd);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL one_shot_cleared_irq: irq=%b required 0", irq); end
        @(posedge clk); #1;
        bus_xfer(32'h0C, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL one_shot_status: read %h required 0", rd); end
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
    endtask

`ifdef TIMER_CMP_PERIODIC_EN
    task automatic test_periodic;
        logic [31:0] rd;
        cnt = '0;
        bus_xfer(32'h00, 1'b1, 32'h10, 4'hF, rd);
        bus_xfer(32'h04, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h10, 1'b1, 32'h10, 4'hF, rd);
        bus_xfer(32'h08, 1'b1, 32'h3, 4'hF, rd);
        for (int i = 0; i < 64; i++) begin
            cnt = 64'(i);
            @(negedge clk);
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL periodic_irq cnt=%0h: irq=%b required %b", i, irq, m_irq);
            end
            tick;
        end
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h40) begin errors++; $display("FAIL periodic_cmp_lo: read %h required 40", rd); end
        bus_xfer(32'h04, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL periodic_cmp_hi: read %h required 0", rd); end
        bus_xfer(32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        bus_xfer(32'h00, 1'b1, 32'hFFFF_FFF8, 4'hF, rd);
        cnt = 64'hFFFF_FFFF_FFFF_FFF8;
        bus_xfer(32'h08, 1'b1, 32'h3, 4'hF, rd);
        cnt = '0;
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL periodic_wrap_lo: read %h required 8", rd); end
        bus_xfer(32'h04, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL periodic_wrap_hi: read %h required 0", rd); end
        bus_xfer(32'h0C, 1'b1, 32'h1, 4'hF, rd);
    endtask
`else
    task automatic test_macro_off;
        logic [31:0] rd;
        cnt = '0;
        bus_xfer(32'h10, 1'b1, 32'h5, 4'hF, rd);
        bus_xfer(32'h08, 1'b1, 32'h3, 4'hF, rd);
        bus_xfer(32'h10, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL macro_off_period: read %h required 0", rd); end
        bus_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL macro_off_ctrl: read %h required 1", rd); end
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b1, 32'h10, 4'hF, rd);
        bus_xfer(32'h04, 1'b1, 32'h0, 4'hF, rd);
        cnt = 64'h20;
        bus_xfer(32'h08, 1'b1, 32'h3, 4'hF, rd);
        repeat (5) tick;
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL macro_off_irq: irq=%b required 1", irq); end
        @(posedge clk); #1;
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("FAIL macro_off_cmp_fixed: read %h required 10", rd); end
        cnt = '0;
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h0C, 1'b1, 32'h1, 4'hF, rd);
    endtask
`endif

    task automatic test_handshake;
        logic [31:0] rd;
        logic [31:0] held;
        logic [31:0] wv[4];
        logic [31:0] wa[4];
        int pulses = 0;
        cnt = '0;
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b1, 32'h0000_5A5A, 4'hF, rd);
        req = 1'b1; wrcs = 1'b0; addr = 32'h00; rdy = 1'b0;
        tick;
        addr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            held = rdata;
            checks++;
            if (rsp !== 1'b1 || gnt !== 1'b0 || held !== 32'h5A5A) begin
                errors++;
                $display("FAIL hold_cycle %0d: rsp=%b gnt=%b rdata=%h required 1 0 5a5a", i, rsp, gnt, held);
            end
            tick;
        end
        rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL hold_release_gnt: gnt=%b required 1", gnt); end
        tick;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL hold_second_read: rsp=%b rdata=%h required 1 0", rsp, rdata);
        end
        tick;
        @(negedge clk);
        checks++;
        if (rsp !== 1'b0) begin errors++; $display("FAIL hold_rsp_drop: rsp=%b required 0", rsp); end
        @(posedge clk); #1;
        wa[0] = 32'h00; wa[1] = 32'h04; wa[2] = 32'h00; wa[3] = 32'h04;
        for (int i = 0; i < 4; i++) wv[i] = $urandom;
        req = 1'b1; wrcs = 1'b1; mask = 4'hF; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = wa[i]; wdata = wv[i];
            @(negedge clk);
            checks++;
            if (gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt %0d: gnt=%b required 1", i, gnt); end
            if (rsp === 1'b1) pulses++;
            tick;
        end
        req = 1'b0; wrcs = 1'b0;
        @(negedge clk);
        if (rsp === 1'b1) pulses++;
        tick;
        @(negedge clk);
        if (rsp === 1'b1) pulses++;
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL b2b_rsp_count: saw %0d required 4", pulses); end
        @(posedge clk); #1;
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== wv[2]) begin errors++; $display("FAIL b2b_cmp_lo: read %h required %h", rd, wv[2]); end
        bus_xfer(32'h04, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== wv[3]) begin errors++; $display("FAIL b2b_cmp_hi: read %h required %h", rd, wv[3]); end
    endtask

    task automatic test_byte_mask;
        logic [31:0] rd;
        bus_xfer(32'h00, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b1, 32'hAABB_CCDD, 4'b0101, rd);
        bus_xfer(32'h00, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL mask_cmp_lo: read %h required 00bb00dd", rd); end
        bus_xfer(32'h20, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: read %h required 0", rd); end
        bus_xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== 32'h00BB_00DD) begin errors++; $display("FAIL alias_read: read %h required 00bb00dd", rd); end
        bus_xfer(32'h08, 1'b1, 32'hFFFF_FFFC, 4'hF, rd);
        bus_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd);
        checks++;
        if (rd !== (HAS_PER ? 32'h2 : 32'h0)) begin
            errors++;
            $display("FAIL ctrl_unused_bits: read %h required %h", rd, (HAS_PER ? 32'h2 : 32'h0));
        end
        bus_xfer(32'h08, 1'b1, 32'h0, 4'hF, rd);
    endtask

    task automatic test_random;
        logic [7:0]  offs[7];
        logic [7:0]  o;
        logic        exp_gnt;
        logic [31:0] rd;
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
        offs[4] = 8'h10; offs[5] = 8'h20; offs[6] = 8'h14;
        cnt = '0;
        bus_xfer(32'h04, 1'b1, 32'h0, 4'hF, rd);
        bus_xfer(32'h00, 1'b1, 32'($urandom_range(0, 255)), 4'hF, rd);
        for (int c = 0; c < 500; c++) begin
            o     = offs[$urandom_range(0, 6)];
            req   = 1'($urandom_range(0, 1));
            wrcs  = 1'($urandom_range(0, 1));
            addr  = ($urandom & 32'hFFFF_FF00) | {24'b0, o};
            mask  = 4'($urandom_range(0, 15));
            rdy   = ($urandom_range(0, 3) != 0);
            case (o)
                8'h00:   wdata = cnt[31:0] + 32'($urandom_range(0, 64));
                8'h04:   wdata = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'h0;
                8'h10:   wdata = 32'($urandom_range(0, 24));
                default: wdata = $urandom;
            endcase
            cnt = cnt + 64'($urandom_range(0, 3));
            @(negedge clk);
            exp_gnt = req && !(m_rsp && !rdy);
            checks++;
            if (irq !== m_irq || rsp !== m_rsp || gnt !== exp_gnt) begin
                errors++;
                $display("FAIL random_ctl cycle %0d: irq/rsp/gnt=%b%b%b required %b%b%b",
                         c, irq, rsp, gnt, m_irq, m_rsp, exp_gnt);
            end
            if (m_rsp && m_last_rd) begin
                checks++;
                if (rdata !== m_rdata) begin
                    errors++;
                    $display("FAIL random_rdata cycle %0d: rdata=%h required %h", c, rdata, m_rdata);
                end
            end
            tick;
        end
        req = 1'b0; rdy = 1'b1;
        repeat (2) tick;
    endtask

    initial begin
        test_reset();
        test_one_shot();
`ifdef TIMER_CMP_PERIODIC_EN
        test_periodic();
`else
        test_macro_off();
`endif
        test_handshake();
        test_byte_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
